// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder_pkg : shared widths, load/store codes and FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

   localparam int DMEM_DATA_WIDTH = 32;
   localparam int DMEM_WORD_BYTES = 4;
   localparam int DMEM_CNT_WIDTH  = 4;

   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_LB   = 3'b001;
   localparam logic [2:0] LD_LH   = 3'b010;
   localparam logic [2:0] LD_LW   = 3'b011;
   localparam logic [2:0] LD_LBU  = 3'b100;
   localparam logic [2:0] LD_LHU  = 3'b101;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_SB   = 2'b01;
   localparam logic [1:0] ST_SH   = 2'b10;
   localparam logic [1:0] ST_SW   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_lane_ctrl : byte enables, store replication, load extraction, checks
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_lane_ctrl
   import dmem_responder_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  rd_type,
   input  logic [1:0]  wr_type,
   input  logic [31:0] wdata,
   input  logic [31:0] word_rd,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        code_err
);

   logic [31:0] shifted;

   always_comb begin
      byte_en    = 4'b0000;
      wdata_rep  = wdata;
      load_data  = 32'd0;
      misaligned = 1'b0;
      shifted    = word_rd >> {addr_lo, 3'b000};
      // exactly one of load/store must be requested
      code_err   = (rd_type > LD_LHU) || ((rd_type != LD_NONE) == (wr_type != ST_NONE));

      case (wr_type)
         ST_SB: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         ST_SH: begin
            misaligned = addr_lo[0];
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{wdata[15:0]}};
         end
         ST_SW: begin
            misaligned = |addr_lo;
            byte_en    = 4'b1111;
         end
         default: ;
      endcase

      case (rd_type)
         LD_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         LD_LBU: load_data = {24'd0, shifted[7:0]};
         LD_LH: begin
            misaligned = addr_lo[0];
            load_data  = {{16{shifted[15]}}, shifted[15:0]};
         end
         LD_LHU: begin
            misaligned = addr_lo[0];
            load_data  = {16'd0, shifted[15:0]};
         end
         LD_LW: begin
            misaligned = |addr_lo;
            load_data  = word_rd;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : wait-state data memory responder with valid/ready handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DATA_WIDTH  = DMEM_DATA_WIDTH,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_read,
   input  logic [1:0]            req_write,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t                    state, state_nx;
   logic [DMEM_CNT_WIDTH-1:0] cnt, cnt_nx;
   logic [DATA_WIDTH-1:0]     addr_q, wdata_q;
   logic [2:0]                rd_q;
   logic [1:0]                wr_q;

   logic [DATA_WIDTH-1:0]     cur_addr, cur_wdata;
   logic [2:0]                cur_rd;
   logic [1:0]                cur_wr;
   logic [IDX_W-1:0]          idx;
   logic                      accept, go_resp, range_err, misaligned, code_err, err, mem_we;
   logic [3:0]                byte_en;
   logic [31:0]               wdata_rep, load_data, word_rd;
   logic [31:0]               mem [DEPTH_WORDS];

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign accept    = req_valid & req_ready;

   // With zero wait states the commit happens on the accept edge itself,
   // so the live request fields must feed the lane logic while idle.
   assign cur_addr  = (state == S_IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
   assign cur_rd    = (state == S_IDLE) ? req_read  : rd_q;
   assign cur_wr    = (state == S_IDLE) ? req_write : wr_q;
   assign idx       = cur_addr[IDX_W+1:2];

   generate
      if (DATA_WIDTH > IDX_W + 2) begin : g_range
         assign range_err = |cur_addr[DATA_WIDTH-1:IDX_W+2];
      end else begin : g_norange
         assign range_err = 1'b0;
      end
   endgenerate

   dmem_lane_ctrl u_lane (
      .addr_lo    (cur_addr[1:0]),
      .rd_type    (cur_rd),
      .wr_type    (cur_wr),
      .wdata      (cur_wdata[31:0]),
      .word_rd    (word_rd),
      .byte_en    (byte_en),
      .wdata_rep  (wdata_rep),
      .load_data  (load_data),
      .misaligned (misaligned),
      .code_err   (code_err)
   );

   assign err     = range_err | misaligned | code_err;
   assign word_rd = mem[idx];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_nx = S_RESP;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = DMEM_CNT_WIDTH'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt == '0) state_nx = S_RESP;
            else           cnt_nx   = cnt - 1'b1;
         end
         S_RESP: begin
            if (rsp_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign go_resp = (state != S_RESP) && (state_nx == S_RESP);
   assign mem_we  = go_resp & ~err & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= LD_NONE;
         wr_q      <= ST_NONE;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_read;
            wr_q    <= req_write;
         end
         if (go_resp) begin
            rsp_err   <= err;
            rsp_rdata <= err ? '0 : DATA_WIDTH'(load_data);
         end else if (rsp_valid && rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
         if (mem_we && byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder : vector table, corner sequences and randomized model check
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [2:0]  req_read;
   logic [1:0]  req_write;

   logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err;
   logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
   logic [2:0]  z_req_read;
   logic [1:0]  z_req_write;

   int checks = 0;
   int failures = 0;
   logic [31:0] mdl [16];

   always #5 clk = ~clk;

   dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
      .req_addr(z_req_addr), .req_read(z_req_read), .req_write(z_req_write),
      .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
      .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
   );

   typedef struct {
      logic [2:0]  rd;
      logic [1:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: access size and alignment rules, byte-array view of the words.
   task automatic model_step(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                             input logic [31:0] wd, output logic err, output logic [31:0] rdata);
      int nb, off, w;
      logic [31:0] v;
      err = 1'b0; rdata = 32'd0; nb = 0;
      case (rd)
         3'd1, 3'd4: nb = 1;
         3'd2, 3'd5: nb = 2;
         3'd3:       nb = 4;
         3'd0:       nb = 0;
         default:    err = 1'b1;
      endcase
      if (wr != 2'd0) begin
         if (rd != 3'd0) err = 1'b1;
         nb = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
      end else if (rd == 3'd0) begin
         err = 1'b1;
      end
      if (nb != 0 && (addr % nb) != 0) err = 1'b1;
      if ((addr / 4) >= 1024) err = 1'b1;
      if (!err) begin
         w = int'(addr / 4); off = int'(addr % 4);
         if (wr != 2'd0) begin
            for (int b = 0; b < nb; b++) mdl[w][8*(off+b) +: 8] = wd[8*b +: 8];
         end else begin
            v = mdl[w] >> (8 * off);
            if (nb == 1)      v = (rd == 3'd1) ? 32'(signed'(v[7:0]))  : {24'd0, v[7:0]};
            else if (nb == 2) v = (rd == 3'd2) ? 32'(signed'(v[15:0])) : {16'd0, v[15:0]};
            rdata = v;
         end
      end
   endtask

   task automatic do_txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold,
                         output logic err, output logic [31:0] rdata, output int lat);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_read = 3'($urandom); req_write = 2'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
      err = rsp_err; rdata = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, rdata);
         chk("hold_err", {31'd0, rsp_err}, {31'd0, err});
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("ret_req_ready", {31'd0, req_ready}, 32'd1);
      chk("ret_rsp_valid", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic z_txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rdata);
      chk("z_req_ready", {31'd0, z_req_ready}, 32'd1);
      z_req_valid = 1'b1; z_req_read = rd; z_req_write = wr; z_req_addr = addr; z_req_wdata = wd;
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      chk("z_lat1_valid", {31'd0, z_rsp_valid}, 32'd1);
      chk("z_rdata", z_rsp_rdata, exp_rdata);
      chk("z_err", {31'd0, z_rsp_err}, 32'd0);
      z_rsp_ready = 1'b1;
      @(posedge clk); #1;
      z_rsp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e, me;
      logic [31:0] r, mr, d;
      int          lat, cls, hold;
      logic [2:0]  rd;
      logic [1:0]  wr;
      logic [31:0] addr;

      tbl[0]  = '{3'b000, 2'b11, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{3'b011, 2'b00, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
      tbl[2]  = '{3'b001, 2'b00, 32'h13,   32'h0,        1'b0, 32'hFFFFFFDE};
      tbl[3]  = '{3'b100, 2'b00, 32'h13,   32'h0,        1'b0, 32'h000000DE};
      tbl[4]  = '{3'b010, 2'b00, 32'h10,   32'h0,        1'b0, 32'hFFFFBEEF};
      tbl[5]  = '{3'b101, 2'b00, 32'h12,   32'h0,        1'b0, 32'h0000DEAD};
      tbl[6]  = '{3'b000, 2'b10, 32'h11,   32'h1234,     1'b1, 32'h0};
      tbl[7]  = '{3'b011, 2'b00, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
      tbl[8]  = '{3'b011, 2'b00, 32'h1000, 32'h0,        1'b1, 32'h0};
      tbl[9]  = '{3'b110, 2'b00, 32'h10,   32'h0,        1'b1, 32'h0};
      tbl[10] = '{3'b011, 2'b11, 32'h10,   32'h0,        1'b1, 32'h0};

      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0; req_wdata = '0;
      req_read = '0; req_write = '0;
      z_req_valid = 1'b0; z_rsp_ready = 1'b0; z_req_addr = '0; z_req_wdata = '0;
      z_req_read = '0; z_req_write = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int w = 0; w < 16; w++) begin
         d = $urandom;
         model_step(3'b000, 2'b11, 32'(w * 4), d, me, mr);
         do_txn(3'b000, 2'b11, 32'(w * 4), d, 0, e, r, lat);
         chk("init_err", {31'd0, e}, 32'd0);
      end

      for (int i = 0; i < 11; i++) begin
         do_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 0, e, r, lat);
         model_step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, me, mr);
         chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err});
         chk($sformatf("tbl%0d_rdata", i), r, tbl[i].rdata);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
      end

      // backpressure: five stalled cycles in RESP
      do_txn(3'b011, 2'b00, 32'h10, 32'h0, 5, e, r, lat);
      chk("bp_rdata", r, 32'hDEADBEEF);

      // reset while a store is still waiting to commit
      req_valid = 1'b1; req_read = 3'b000; req_write = 2'b11; req_addr = 32'h20; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      model_step(3'b011, 2'b00, 32'h20, 32'h0, me, mr);
      do_txn(3'b011, 2'b00, 32'h20, 32'h0, 0, e, r, lat);
      chk("abandon_rdata", r, mr);
      chk("abandon_err", {31'd0, e}, 32'd0);

      // reset while a response is pending
      req_valid = 1'b1; req_read = 3'b011; req_write = 2'b00; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("resp_pending_valid", {31'd0, rsp_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("resp_rst_rdata", rsp_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // zero-wait-state build
      z_txn(3'b000, 2'b11, 32'h8, 32'hA5A51234, 32'h0);
      z_txn(3'b011, 2'b00, 32'h8, 32'h0, 32'hA5A51234);
      z_txn(3'b001, 2'b00, 32'hB, 32'h0, 32'hFFFFFFA5);

      for (int n = 0; n < 300; n++) begin
         cls = $urandom_range(0, 9);
         addr = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 0) begin rd = 3'($urandom_range(1, 5)); wr = 2'b00; end
         else begin rd = 3'b000; wr = 2'($urandom_range(1, 3)); end
         case (cls)
            0: begin rd = 3'($urandom_range(6, 7)); wr = 2'b00; end
            1: begin rd = 3'($urandom_range(1, 5)); wr = 2'($urandom_range(1, 3)); end
            2: begin rd = 3'b000; wr = 2'b00; end
            3: addr = $urandom | 32'h0000_1000;
            default: ;
         endcase
         d = $urandom;
         hold = $urandom_range(0, 2);
         model_step(rd, wr, addr, d, me, mr);
         do_txn(rd, wr, addr, d, hold, e, r, lat);
         chk("rnd_err", {31'd0, e}, {31'd0, me});
         chk("rnd_rdata", r, mr);
         chk("rnd_latency", 32'(lat), 32'd3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width in bits.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-003 Parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-004 Reset is decided: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state rising-edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  1  initiator presents a request.
REQ-008 req_ready  output  1  responder can accept a request.
REQ-009 req_addr  input  DATA_WIDTH  byte address.
REQ-010 req_read  input  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, others illegal.
REQ-011 req_write  input  2  store type: 00 none, 01 SB, 10 SH, 11 SW.
REQ-012 req_wdata  input  DATA_WIDTH  store data, LSB-aligned.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  initiator accepts response.
REQ-015 rsp_rdata  output  DATA_WIDTH  load result, sign/zero-extended; 0 for stores and errors.
REQ-016 rsp_err  output  1  request rejected (misaligned, out of range, illegal code).

Function
REQ-017 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept = req_valid & req_ready; request fields SHALL be registered at accept; inputs ignored otherwise.
REQ-019 IDLE->WAIT on accept when WAIT_CYCLES>0, loading wait counter with WAIT_CYCLES-1; IDLE->RESP when WAIT_CYCLES=0.
REQ-020 WAIT SHALL decrement counter each cycle and go to RESP when counter is 0; rsp_valid first high exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-021 RESP holds rsp_valid, rsp_rdata, rsp_err stable until rsp_valid & rsp_ready, then SHALL return to IDLE (req_ready high next cycle; no same-cycle back-to-back accept).
REQ-022 Store SHALL commit to storage on the WAIT/IDLE->RESP transition edge, byte lanes per addr[1:0] (SB any lane, SH lanes 0-1 or 2-3, SW all).
REQ-023 Load data SHALL be sampled from storage on the same transition edge; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-024 Error when: halfword with addr[0]=1; word with addr[1:0]!=0; word index addr[31:2] >= DEPTH_WORDS; illegal req_read code; both req_read and req_write non-zero; both zero.
REQ-025 On error: no storage write, rsp_err=1, rsp_rdata=0, latency unchanged.
REQ-026 Word index SHALL use addr[log2(DEPTH_WORDS)+1:2]; no wrap-around—out-of-range addresses error, never alias.
REQ-027 Wait counter width 4 bits; no overflow possible within parameter range.

Reset
REQ-028 rst SHALL asynchronously force state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, req_ready 1 after release.
REQ-029 Reset mid-WAIT or mid-RESP SHALL abandon the transaction; a store not yet committed SHALL NOT commit.
REQ-030 Storage contents SHALL NOT be reset.

Structure
REQ-031 Load/store type codes, FSM state encoding and DATA_WIDTH SHALL live in the shared defines package alongside the existing width macros.
REQ-032 One sub-module, dmem_lane_ctrl (combinational): byte-enable generation, store lane replication, load extraction/extension, misalignment detect.

Verification
REQ-033 WAIT_CYCLES=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> each rsp_valid 3 cycles after accept, LW rdata 0xDEADBEEF, rsp_err 0.
REQ-034 After REQ-033 data: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-035 SH 0x1234 to 0x11 -> rsp_err 1, rdata 0; subsequent LW 0x10 still 0xDEADBEEF.
REQ-036 LW 0x1000 (DEPTH_WORDS=1024) -> rsp_err 1; req_read=3'b110 -> rsp_err 1; req_read=011 with req_write=11 -> rsp_err 1.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata stable, req_ready 0; rsp_ready=1 -> IDLE next cycle.
REQ-038 Assert rst one cycle after accepting SW 0x55 to 0x20 -> outputs reset immediately; LW 0x20 afterwards returns prior contents, not 0x55; WAIT_CYCLES=0 build shows rsp_valid 1 cycle after accept.
